// File: rtl/pad_mmio_writer.sv
// Frame-driven MMIO writer: on each new_frame tick it pushes the pad state, an LFSR
// random byte and (on fresh presses) an ASCII key code into system RAM via req/grant.
module pad_mmio_writer #(
    parameter logic [10:0] PAD_ADDR  = 11'h00A,
    parameter logic [10:0] RAND_ADDR = 11'h0FE,
    parameter logic [10:0] KEY_ADDR  = 11'h0FF,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        new_frame,
    input  logic [11:0] pad,
    output logic        req,
    input  logic        grant,
    output logic [10:0] waddr,
    output logic [7:0]  wdata,
    output logic        write_en,
    output logic [7:0]  dropped_frames
);

    localparam logic [15:0] SEED_EFF  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    typedef enum logic [1:0] {
        IDLE,
        PAD,
        RAND,
        KEY
    } state_t;

    state_t      state_q;
    logic        req_q;
    logic [10:0] waddr_q;
    logic [7:0]  wdata_q;
    logic [7:0]  drop_q;
    logic [7:0]  prev_q;
    logic [7:0]  rbyte_q;
    logic [7:0]  kcode_q;
    logic        key_pend_q;
    logic        nf_q;
    logic [15:0] lfsr_q;

    logic        tick;
    logic [7:0]  newp_d;
    logic [7:0]  kcode_d;
    logic [15:0] lfsr_d;
    logic        unused_pad_bits;

    // Shoulder, start and select buttons have no key code and no RAM slot.
    assign unused_pad_bits = ^pad[11:8];

    assign tick   = new_frame & ~nf_q;
    assign newp_d = pad[7:0] & ~prev_q;
    assign lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_MASK) : (lfsr_q >> 1);

    always_comb begin
        kcode_d = 8'h00;
        if (newp_d[0])      kcode_d = 8'h61;
        else if (newp_d[1]) kcode_d = 8'h64;
        else if (newp_d[2]) kcode_d = 8'h77;
        else if (newp_d[3]) kcode_d = 8'h73;
        else if (newp_d[4]) kcode_d = 8'h6A;
        else if (newp_d[5]) kcode_d = 8'h6B;
        else if (newp_d[6]) kcode_d = 8'h69;
        else if (newp_d[7]) kcode_d = 8'h75;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            waddr_q    <= 11'h000;
            wdata_q    <= 8'h00;
            drop_q     <= 8'h00;
            prev_q     <= 8'h00;
            rbyte_q    <= 8'h00;
            kcode_q    <= 8'h00;
            key_pend_q <= 1'b0;
            nf_q       <= 1'b0;
            lfsr_q     <= SEED_EFF;
        end else begin
            nf_q   <= new_frame;
            lfsr_q <= lfsr_d;

            // A tick while busy is dropped; prev stays put so its presses are seen next frame.
            if (tick && (state_q != IDLE) && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end

            case (state_q)
                IDLE: begin
                    if (tick) begin
                        prev_q     <= pad[7:0];
                        rbyte_q    <= lfsr_q[7:0];
                        kcode_q    <= kcode_d;
                        key_pend_q <= |newp_d;
                        req_q      <= 1'b1;
                        waddr_q    <= PAD_ADDR;
                        wdata_q    <= pad[7:0];
                        state_q    <= PAD;
                    end
                end
                PAD: begin
                    if (grant) begin
                        waddr_q <= RAND_ADDR;
                        wdata_q <= rbyte_q;
                        state_q <= RAND;
                    end
                end
                RAND: begin
                    if (grant) begin
                        if (key_pend_q) begin
                            waddr_q <= KEY_ADDR;
                            wdata_q <= kcode_q;
                            state_q <= KEY;
                        end else begin
                            req_q   <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                KEY: begin
                    if (grant) begin
                        key_pend_q <= 1'b0;
                        req_q      <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    req_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req            = req_q;
    assign waddr          = waddr_q;
    assign wdata          = wdata_q;
    assign write_en       = req_q & grant;
    assign dropped_frames = drop_q;

endmodule

// File: tb/tb_pad_mmio_writer.sv
// Bench for pad_mmio_writer: directed vector table, hand-written handshake corners and a
// random run, all checked against a queue-of-pending-writes model of the frame rules.
module tb_pad_mmio_writer;

    localparam logic [10:0] PAD_A  = 11'h00A;
    localparam logic [10:0] RAND_A = 11'h0FE;
    localparam logic [10:0] KEY_A  = 11'h0FF;
    localparam logic [15:0] SEED   = 16'hACE1;
    localparam logic [7:0]  KEY_CODES [8] = '{8'h61, 8'h64, 8'h77, 8'h73, 8'h6A, 8'h6B, 8'h69, 8'h75};

    logic        clk = 1'b0;
    logic        reset_n;
    logic        new_frame;
    logic [11:0] pad;
    logic        grant;
    logic        req;
    logic [10:0] waddr;
    logic [7:0]  wdata;
    logic        write_en;
    logic [7:0]  dropped_frames;

    pad_mmio_writer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .new_frame      (new_frame),
        .pad            (pad),
        .req            (req),
        .grant          (grant),
        .waddr          (waddr),
        .wdata          (wdata),
        .write_en       (write_en),
        .dropped_frames (dropped_frames)
    );

    always #5 clk = ~clk;

    int nCompared = 0;
    int nMismatch = 0;

    typedef struct packed {
        logic [10:0] addr;
        logic [7:0]  data;
    } wr_t;

    // The model is just the list of writes still owed to RAM; its head is the live request.
    wr_t         expQ[$];
    logic [15:0] mLfsr;
    logic [7:0]  mPrev;
    logic [7:0]  mDrop;
    logic        mNf;

    typedef struct packed {
        logic        nf;
        logic [11:0] pad;
        logic        grant;
        logic        expReq;
        logic [10:0] expAddr;
        logic [7:0]  expData;
        logic        chkData;
        logic        expWe;
    } vec_t;

    vec_t vecs [16];

    function automatic logic [15:0] lfsrStep(input logic [15:0] x);
        return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    endfunction

    function automatic logic [7:0] keyCode(input logic [7:0] newp);
        for (int i = 0; i < 8; i++) begin
            if (newp[i]) return KEY_CODES[i];
        end
        return 8'h00;
    endfunction

    task automatic compare(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatch++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        expQ.delete();
        mLfsr = SEED;
        mPrev = 8'h00;
        mDrop = 8'h00;
        mNf   = 1'b0;
    endtask

    task automatic modelEdge();
        logic tick;
        logic busy;
        logic [7:0] newp;
        tick = new_frame & ~mNf;
        mNf  = new_frame;
        busy = (expQ.size() != 0);
        if (busy && grant) void'(expQ.pop_front());
        if (tick) begin
            if (busy) begin
                if (mDrop != 8'hFF) mDrop = mDrop + 8'd1;
            end else begin
                newp  = pad[7:0] & ~mPrev;
                mPrev = pad[7:0];
                expQ.push_back('{addr: PAD_A, data: pad[7:0]});
                expQ.push_back('{addr: RAND_A, data: mLfsr[7:0]});
                if (newp != 8'h00) expQ.push_back('{addr: KEY_A, data: keyCode(newp)});
            end
        end
        mLfsr = lfsrStep(mLfsr);
    endtask

    task automatic checkOutput();
        logic expReq;
        expReq = (expQ.size() != 0);
        compare("req", req, expReq);
        compare("write_en", write_en, expReq & grant);
        compare("dropped_frames", dropped_frames, mDrop);
        if (expReq) begin
            compare("waddr", waddr, expQ[0].addr);
            compare("wdata", wdata, expQ[0].data);
        end
    endtask

    task automatic applyStimulus(input logic nf, input logic [11:0] p, input logic g);
        @(negedge clk);
        new_frame = nf;
        pad       = p;
        grant     = g;
        #1;
    endtask

    task automatic finishCycle();
        @(posedge clk);
        if (reset_n) modelEdge();
    endtask

    task automatic runCycle(input logic nf, input logic [11:0] p, input logic g);
        applyStimulus(nf, p, g);
        checkOutput();
        finishCycle();
    endtask

    task automatic doReset();
        reset_n   = 1'b0;
        new_frame = 1'b0;
        pad       = 12'h000;
        grant     = 1'b1;
        #1;
        modelReset();
        compare("rst_req", req, 1'b0);
        compare("rst_write_en", write_en, 1'b0);
        compare("rst_waddr", waddr, 11'h000);
        compare("rst_wdata", wdata, 8'h00);
        compare("rst_dropped", dropped_frames, 8'h00);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
    endtask

    initial begin
        vecs = '{
            '{1'b0, 12'h004, 1'b1, 1'b0, 11'h000, 8'h00, 1'b0, 1'b0},
            '{1'b1, 12'h004, 1'b1, 1'b0, 11'h000, 8'h00, 1'b0, 1'b0},
            '{1'b1, 12'h004, 1'b1, 1'b1, PAD_A,   8'h04, 1'b1, 1'b1},
            '{1'b0, 12'h004, 1'b1, 1'b1, RAND_A,  8'h00, 1'b0, 1'b1},
            '{1'b0, 12'h004, 1'b1, 1'b1, KEY_A,   8'h77, 1'b1, 1'b1},
            '{1'b0, 12'h004, 1'b1, 1'b0, 11'h000, 8'h00, 1'b0, 1'b0},
            '{1'b1, 12'h004, 1'b1, 1'b0, 11'h000, 8'h00, 1'b0, 1'b0},
            '{1'b0, 12'h004, 1'b1, 1'b1, PAD_A,   8'h04, 1'b1, 1'b1},
            '{1'b0, 12'h004, 1'b1, 1'b1, RAND_A,  8'h00, 1'b0, 1'b1},
            '{1'b0, 12'h004, 1'b1, 1'b0, 11'h000, 8'h00, 1'b0, 1'b0},
            '{1'b0, 12'h009, 1'b1, 1'b0, 11'h000, 8'h00, 1'b0, 1'b0},
            '{1'b1, 12'h009, 1'b1, 1'b0, 11'h000, 8'h00, 1'b0, 1'b0},
            '{1'b0, 12'h009, 1'b1, 1'b1, PAD_A,   8'h09, 1'b1, 1'b1},
            '{1'b0, 12'h009, 1'b1, 1'b1, RAND_A,  8'h00, 1'b0, 1'b1},
            '{1'b0, 12'h009, 1'b1, 1'b1, KEY_A,   8'h61, 1'b1, 1'b1},
            '{1'b0, 12'h009, 1'b1, 1'b0, 11'h000, 8'h00, 1'b0, 1'b0}
        };

        doReset();

        for (int i = 0; i < 100; i++) runCycle(1'b0, 12'h000, 1'b0);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].nf, vecs[i].pad, vecs[i].grant);
            compare($sformatf("vec%0d_req", i), req, vecs[i].expReq);
            compare($sformatf("vec%0d_we", i), write_en, vecs[i].expWe);
            if (vecs[i].expReq) compare($sformatf("vec%0d_addr", i), waddr, vecs[i].expAddr);
            if (vecs[i].chkData) compare($sformatf("vec%0d_data", i), wdata, vecs[i].expData);
            checkOutput();
            finishCycle();
        end

        // Stalled grant with a second tick arriving mid-stall.
        runCycle(1'b1, 12'h009, 1'b0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus((i < 5 || i >= 10), 12'h009, 1'b0);
            compare("stall_req", req, 1'b1);
            compare("stall_waddr", waddr, PAD_A);
            compare("stall_we", write_en, 1'b0);
            checkOutput();
            finishCycle();
        end
        compare("stall_dropped", dropped_frames, 8'h01);
        for (int i = 0; i < 5; i++) runCycle(1'b0, 12'h009, 1'b1);

        // No buttons at all: pad and random writes only.
        for (int i = 0; i < 2; i++) runCycle(1'b0, 12'h000, 1'b1);
        runCycle(1'b1, 12'h000, 1'b1);
        for (int i = 0; i < 4; i++) runCycle(1'b0, 12'h000, 1'b1);

        // Reset arriving while the random-byte write is outstanding.
        runCycle(1'b0, 12'h010, 1'b0);
        runCycle(1'b1, 12'h010, 1'b0);
        runCycle(1'b0, 12'h010, 1'b1);
        #1;
        compare("pre_rst_req", req, 1'b1);
        compare("pre_rst_waddr", waddr, RAND_A);
        #1;
        doReset();
        for (int i = 0; i < 3; i++) runCycle(1'b0, 12'h010, 1'b1);
        runCycle(1'b1, 12'h010, 1'b1);
        for (int i = 0; i < 5; i++) runCycle(1'b0, 12'h010, 1'b1);

        // Many ticks with no grant drive the drop counter into saturation.
        for (int i = 0; i < 300; i++) begin
            runCycle(1'b1, 12'h020, 1'b0);
            runCycle(1'b0, 12'h020, 1'b0);
        end
        compare("drop_saturated", dropped_frames, 8'hFF);
        for (int i = 0; i < 5; i++) runCycle(1'b0, 12'h020, 1'b1);

        begin
            logic        nf;
            logic [11:0] p;
            nf = 1'b0;
            p  = 12'h000;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 3) == 0) nf = ~nf;
                if ($urandom_range(0, 15) == 0) p = 12'($urandom);
                runCycle(nf, p, ($urandom_range(0, 3) != 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule

// File: doc/pad_mmio_writer.md
# pad_mmio_writer

Per-frame memory-mapped peripheral writer that sits beside `snespad` and feeds the shared 2 KiB system RAM through the RAM write mux. It performs up to three writes on every frame tick:
- the raw pad state;
- an LFSR random byte;
- an easy6502-style ASCII key code, on new button presses only.

Each write completes through a request/grant handshake with the RAM arbiter. This replaces the fixed `pad1[7:0]`-at-address-10 wiring of the top level.

## Interface
Parameters:
- `PAD_ADDR`, 11'h00A, RAM address receiving `pad[7:0]` each frame
- `RAND_ADDR`, 11'h0FE, RAM address receiving the random byte each frame
- `KEY_ADDR`, 11'h0FF, RAM address receiving the ASCII code of a new press
- `LFSR_SEED`, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'h0001

Ports:
- `clk`  in  1  system clock (25.125 MHz domain)
- `reset_n`  in  1  asynchronous active-low reset
- `new_frame`  in  1  frame marker, synchronous to `clk`; its rising edge is the frame tick
- `pad`  in  12  button levels from `snespad`, 1 = pressed; bit order is left, right, up, down, A, B, X, Y, L, R, start, select
- `req`  out  1  write request to the arbiter, registered
- `grant`  in  1  arbiter grants the RAM write port this cycle
- `waddr`  out  11  write address, registered, stable while `req`=1
- `wdata`  out  8  write data, registered, stable while `req`=1
- `write_en`  out  1  RAM write strobe, combinational: `req & grant`
- `dropped_frames`  out  8  saturating count of frame ticks ignored while the block was busy

One clock; reset is asynchronous and active-low.

## Operation
- LFSR: 16-bit Galois, mask 16'hB400, shifting right. It advances every `clk` cycle regardless of state; this free-running behaviour is the entropy source.
- Frame tick: `tick = new_frame & ~nf_d`, where `nf_d` is `new_frame` registered.
- States: IDLE, PAD, RAND, KEY.
- IDLE with `tick`:
  - latch `snap = pad[7:0]` and `rbyte = lfsr[7:0]`;
  - compute `newp = pad[7:0] & ~prev`, then set `prev <= pad[7:0]`;
  - set `key_pend = |newp`;
  - encode `kcode` from the lowest set bit of `newp`: left 8'h61, right 8'h64, up 8'h77, down 8'h73, A 8'h6A, B 8'h6B, X 8'h69, Y 8'h75;
  - go to PAD.
- PAD: `req`=1, `waddr=PAD_ADDR`, `wdata=snap`. On `grant` go to RAND.
- RAND: `req`=1, `waddr=RAND_ADDR`, `wdata=rbyte`. On `grant` go to KEY if `key_pend`, else go to IDLE.
- KEY: `req`=1, `waddr=KEY_ADDR`, `wdata=kcode`. On `grant` clear `key_pend` and go to IDLE.
- Without `grant`, the state holds and `req`/`waddr`/`wdata` stay unchanged for any number of cycles.
- `tick` in any state other than IDLE: the frame is dropped and `dropped_frames` increments, saturating at 8'hFF. `prev` is not updated, so a press that occurs during the dropped frame is still reported on the next accepted frame.
- Releases produce no key write. `KEY_ADDR` keeps the last code written until software clears it.
- L, R, start and select are ignored.

## Timing
- Reset values:
  - state IDLE;
  - `req`=0, `waddr`=0, `wdata`=0, `write_en`=0, `dropped_frames`=0;
  - `prev`=0, `nf_d`=0, `key_pend`=0, LFSR=seed.
- Latency: with `tick` in cycle N, `req` rises in cycle N+1.
- With `grant` held at 1, writes occur in cycles N+1, N+2 and N+3 (the third only when a key is pending). `req` falls in N+3, or in N+4 when the key write occurs.
- Exactly one `write_en` pulse occurs per granted cycle. `grant` while `req`=0 has no effect.
- The next state after a granted cycle is presented on the following cycle. Writes are not back-to-back to the same address.
- `reset_n` asserted mid-handshake: `req` drops immediately (asynchronous) and any pending write is abandoned.
- `new_frame` held high produces a single tick; the next tick needs a low-then-high transition.

## Test plan
- Reset → all outputs 0; release reset and hold `new_frame`=0 for 100 cycles → `req` stays 0.
- `pad`=12'h000 (no press), tick, `grant`=1 → writes (10, 8'h00), then (254, lfsr low byte); no write to 255; `req` low in cycle N+3.
- `pad`=12'h004 (up) held for two ticks → first frame writes 10←8'h04, then RAND, then 255←8'h77; second frame has no write to 255.
- `pad`=12'h009 (left and down newly pressed together) → 255←8'h61 (left wins by priority).
- Hold `grant`=0 for 20 cycles after a tick → `req`=1 with `waddr`=10 stable and `write_en`=0. A second tick during this window → `dropped_frames`=1. Then grant → normal sequence completes.
- Pulse `reset_n` low while in RAND with `req`=1 → `req`=0 within the same cycle, state IDLE, LFSR back to 16'hACE1.
